// File: rtl/flow_word_packer.sv
// Width up-converter: packs up to K consecutive N-bit words into one K*N-bit beat
// on a registered valid/ready output; last_in closes a short beat early.
module flow_word_packer #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic                  last_in,
  input  logic [N-1:0]          d_in,
  output logic                  ready_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [K*N-1:0]        d_out,
  output logic [$clog2(K):0]    cnt_out,
  output logic                  last_out
);

  localparam int             CW      = $clog2(K);
  localparam logic [CW-1:0]  CNT_MAX = CW'(K - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [(K-1)*N-1:0]    acc_q, acc_d;
  logic [K*N-1:0]        d_out_q, d_out_d;
  logic [CW:0]           cnt_out_q, cnt_out_d;
  logic                  last_out_q, last_out_d;
  logic                  valid_out_q, valid_out_d;

  logic                  is_full;
  logic                  accept;
  logic                  completing;
  logic                  drain;
  logic [K*N-1:0]        acc_ext;
  logic [K*N-1:0]        beat;

  // Stage boundary: accumulator and slot counter feed the output register.
  always_comb begin
    is_full    = (cnt_q == CNT_MAX);
    // Non-completing words never need the output register, so they bypass backpressure.
    ready_out  = (~is_full & ~last_in) | ~valid_out_q | ready_in;
    accept     = valid_in & ready_out;
    completing = is_full | last_in;
    drain      = valid_out_q & ready_in;

    // Zero-padded view so the top slot can be indexed uniformly.
    acc_ext = {{N{1'b0}}, acc_q};
    beat    = '0;
    for (int i = 0; i < K; i++) begin
      if (CW'(i) < cnt_q) begin
        beat[i*N +: N] = acc_ext[i*N +: N];
      end else if (CW'(i) == cnt_q) begin
        beat[i*N +: N] = d_in;
      end
    end

    cnt_d       = cnt_q;
    acc_d       = acc_q;
    d_out_d     = d_out_q;
    cnt_out_d   = cnt_out_q;
    last_out_d  = last_out_q;
    valid_out_d = valid_out_q;

    if (drain) begin
      valid_out_d = 1'b0;
    end

    if (accept) begin
      if (completing) begin
        d_out_d     = beat;
        cnt_out_d   = (CW+1)'(cnt_q) + (CW+1)'(1);
        last_out_d  = last_in;
        valid_out_d = 1'b1;
        cnt_d       = '0;
        acc_d       = '0;
      end else begin
        for (int i = 0; i < K - 1; i++) begin
          if (CW'(i) == cnt_q) begin
            acc_d[i*N +: N] = d_in;
          end
        end
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Stage boundary: registered state and output beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      d_out_q     <= '0;
      cnt_out_q   <= '0;
      last_out_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      d_out_q     <= d_out_d;
      cnt_out_q   <= cnt_out_d;
      last_out_q  <= last_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign d_out     = d_out_q;
  assign cnt_out   = cnt_out_q;
  assign last_out  = last_out_q;

endmodule

// File: tb/tb_flow_word_packer.sv
// Directed bench for flow_word_packer (N=4, K=4) with hand-computed expected beats.
module tb_flow_word_packer;

  localparam int N = 4;
  localparam int K = 4;

  logic          clk;
  logic          rst;
  logic          valid_in;
  logic          last_in;
  logic [N-1:0]  d_in;
  logic          ready_out;
  logic          valid_out;
  logic          ready_in;
  logic [K*N-1:0] d_out;
  logic [2:0]    cnt_out;
  logic          last_out;

  int n_tests = 0;
  int n_fail  = 0;

  flow_word_packer #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .last_in   (last_in),
    .d_in      (d_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .d_out     (d_out),
    .cnt_out   (cnt_out),
    .last_out  (last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs and outputs are handled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [N-1:0] w, input logic l);
    valid_in = 1'b1;
    d_in     = w;
    last_in  = l;
    #1;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    last_in  = 1'b0;
    d_in     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b0;
    ready_in = 1'b1;
    idle();
    #2;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
    do_reset();

    // Single beat 1,2,3,4
    for (int i = 1; i <= 4; i++) begin
      present(N'(i), 1'b0);
      check("single_pre_valid", 32'(valid_out), 32'd0);
      tick();
    end
    idle();
    check("single_valid", 32'(valid_out), 32'd1);
    check("single_d", 32'(d_out), 32'h4321);
    check("single_cnt", 32'(cnt_out), 32'd4);
    check("single_last", 32'(last_out), 32'd0);
    tick();
    check("single_drained", 32'(valid_out), 32'd0);

    // Sustained stream 0..7
    for (int i = 0; i < 8; i++) begin
      present(N'(i), 1'b0);
      check("stream_ready", 32'(ready_out), 32'd1);
      tick();
      if ((i % 4) == 3) begin
        check("stream_valid", 32'(valid_out), 32'd1);
        check("stream_d", 32'(d_out), (i == 3) ? 32'h3210 : 32'h7654);
        check("stream_cnt", 32'(cnt_out), 32'd4);
      end else begin
        check("stream_gap", 32'(valid_out), 32'd0);
      end
    end
    idle();
    tick();
    check("stream_end", 32'(valid_out), 32'd0);

    // Backpressure
    ready_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      present(N'(i), 1'b0);
      tick();
    end
    check("bp_pending", 32'(valid_out), 32'd1);
    check("bp_pending_d", 32'(d_out), 32'h4321);
    for (int i = 5; i <= 7; i++) begin
      present(N'(i), 1'b0);
      check("bp_accept_ready", 32'(ready_out), 32'd1);
      tick();
      check("bp_hold_d", 32'(d_out), 32'h4321);
    end
    present(4'h8, 1'b0);
    check("bp_block_ready", 32'(ready_out), 32'd0);
    tick();
    check("bp_still_blocked", 32'(ready_out), 32'd0);
    check("bp_still_valid", 32'(valid_out), 32'd1);
    check("bp_still_d", 32'(d_out), 32'h4321);
    check("bp_still_cnt", 32'(cnt_out), 32'd4);
    ready_in = 1'b1;
    #1;
    check("bp_release_ready", 32'(ready_out), 32'd1);
    tick();
    idle();
    check("bp_nobubble_valid", 32'(valid_out), 32'd1);
    check("bp_new_d", 32'(d_out), 32'h8765);
    check("bp_new_cnt", 32'(cnt_out), 32'd4);
    tick();
    check("bp_drained", 32'(valid_out), 32'd0);

    // Short packet, then a single-word packet
    present(4'hA, 1'b0);
    tick();
    present(4'hB, 1'b1);
    tick();
    idle();
    check("short_valid", 32'(valid_out), 32'd1);
    check("short_d", 32'(d_out), 32'h00BA);
    check("short_cnt", 32'(cnt_out), 32'd2);
    check("short_last", 32'(last_out), 32'd1);
    present(4'hC, 1'b1);
    tick();
    idle();
    check("first_last_d", 32'(d_out), 32'h000C);
    check("first_last_cnt", 32'(cnt_out), 32'd1);
    check("first_last_last", 32'(last_out), 32'd1);
    tick();

    // Asynchronous reset with a pending beat, no clock edge
    ready_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      present(N'(i), 1'b0);
      tick();
    end
    idle();
    check("arst_pre_valid", 32'(valid_out), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(valid_out), 32'd0);
    check("arst_d", 32'(d_out), 32'd0);
    check("arst_cnt", 32'(cnt_out), 32'd0);
    check("arst_last", 32'(last_out), 32'd0);
    check("arst_ready", 32'(ready_out), 32'd1);
    tick();
    rst = 1'b1;
    ready_in = 1'b1;

    // Reset mid-packet discards the partial accumulation
    present(4'h9, 1'b0);
    tick();
    present(4'hA, 1'b0);
    tick();
    idle();
    #1;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int i = 5; i <= 8; i++) begin
      present(N'(i), 1'b0);
      tick();
    end
    idle();
    check("mid_rst_valid", 32'(valid_out), 32'd1);
    check("mid_rst_d", 32'(d_out), 32'h8765);
    check("mid_rst_cnt", 32'(cnt_out), 32'd4);
    check("mid_rst_last", 32'(last_out), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
